// File: rtl/scfifo_s_pkg.sv
// Shared types and helpers for the scfifo_s occupancy controller family.
// The occupancy operation is decoded once from the accepted write/read pair.
package scfifo_s_pkg;

  localparam int unsigned ADDR_WIDTH_MIN = 2;
  localparam int unsigned ADDR_WIDTH_MAX = 16;

  typedef enum logic [1:0] {
    OCC_HOLD = 2'd0,
    OCC_INC  = 2'd1,
    OCC_DEC  = 2'd2
  } occ_op_t;

  // Simultaneous accepted write and read cancel out, so they decode to HOLD.
  function automatic occ_op_t occ_decode(input logic wr_acc, input logic rd_acc);
    occ_op_t op;
    case ({wr_acc, rd_acc})
      2'b10:   op = OCC_INC;
      2'b01:   op = OCC_DEC;
      default: op = OCC_HOLD;
    endcase
    return op;
  endfunction

  function automatic int unsigned occ_next(input int unsigned usedw, input occ_op_t op);
    int unsigned nxt;
    case (op)
      OCC_INC: nxt = usedw + 32'd1;
      OCC_DEC: nxt = usedw - 32'd1;
      default: nxt = usedw;
    endcase
    return nxt;
  endfunction

  // Depth from address width; guarded so an oversized width cannot shift out.
  function automatic int unsigned fifo_depth(input int unsigned aw);
    int unsigned d;
    if (aw >= 32'd31) d = 32'd0;
    else              d = 32'd1 << aw;
    return d;
  endfunction

endpackage

// File: rtl/scfifo_s_wrap_ptr.sv
// ADDR_WIDTH-bit FIFO pointer with synchronous active-low reset and enable.
// Wraps DEPTH-1 -> 0 through natural overflow of the register width.
module scfifo_s_wrap_ptr #(
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  i_clk,
  input  logic                  i_sclr_n,
  input  logic                  i_en,
  output logic [ADDR_WIDTH-1:0] o_ptr
);

  logic [ADDR_WIDTH-1:0] r_ptr;

  always_ff @(posedge i_clk) begin
    if (!i_sclr_n) begin
      r_ptr <= '0;
    end else if (i_en) begin
      r_ptr <= r_ptr + ADDR_WIDTH'(1);
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/scfifo_s_occ_ctrl.sv
// Occupancy/pointer controller for the scfifo_s single-clock FIFO; drives an external SDP RAM.
// Optional sticky overflow/underflow flags are built when SCFIFO_S_OCC_ERR_EN is defined.
module scfifo_s_occ_ctrl
  import scfifo_s_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 5,
  parameter int unsigned ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 2,
  parameter int unsigned ALMOST_EMPTY_TH = 2
) (
  input  logic                  clk,
  input  logic                  sclr_n,
  input  logic                  wrreq,
  input  logic                  rdreq,
  output logic                  ram_wren,
  output logic [ADDR_WIDTH-1:0] ram_wraddr,
  output logic [ADDR_WIDTH-1:0] ram_rdaddr,
  output logic                  ram_rden,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned        DEPTH   = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AF_TH   = ALMOST_FULL_TH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_TH   = ALMOST_EMPTY_TH[ADDR_WIDTH:0];

  if (ADDR_WIDTH < ADDR_WIDTH_MIN || ADDR_WIDTH > ADDR_WIDTH_MAX) begin : g_bad_aw
    $error("scfifo_s_occ_ctrl: ADDR_WIDTH out of range");
  end
  if (ALMOST_FULL_TH < 1 || ALMOST_FULL_TH > DEPTH) begin : g_bad_af
    $error("scfifo_s_occ_ctrl: ALMOST_FULL_TH out of range");
  end
  if (ALMOST_EMPTY_TH < 1 || ALMOST_EMPTY_TH > DEPTH) begin : g_bad_ae
    $error("scfifo_s_occ_ctrl: ALMOST_EMPTY_TH out of range");
  end

  logic                  r_full;
  logic                  r_empty;
  logic                  r_almost_full;
  logic                  r_almost_empty;
  logic [ADDR_WIDTH:0]   r_usedw;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  occ_op_t               w_op;
  logic [ADDR_WIDTH:0]   w_usedw_next;
  logic [ADDR_WIDTH-1:0] w_wr_ptr;
  logic [ADDR_WIDTH-1:0] w_rd_ptr;

  // Handshake: a request is accepted in the cycle it is high and the registered
  // flag allows it (write needs ~full, read needs ~empty); reset suppresses both.
  assign w_wr_acc = sclr_n & wrreq & ~r_full;
  assign w_rd_acc = sclr_n & rdreq & ~r_empty;

  assign w_op         = occ_decode(w_wr_acc, w_rd_acc);
  assign w_usedw_next = (ADDR_WIDTH + 1)'(occ_next(32'(r_usedw), w_op));

  scfifo_s_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .i_clk    (clk),
    .i_sclr_n (sclr_n),
    .i_en     (w_wr_acc),
    .o_ptr    (w_wr_ptr)
  );

  scfifo_s_wrap_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .i_clk    (clk),
    .i_sclr_n (sclr_n),
    .i_en     (w_rd_acc),
    .o_ptr    (w_rd_ptr)
  );

  // Flags come from the next count so they always agree with usedw.
  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_usedw        <= '0;
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
    end else begin
      r_usedw        <= w_usedw_next;
      r_full         <= (w_usedw_next == DEPTH_W);
      r_empty        <= (w_usedw_next == '0);
      r_almost_full  <= (w_usedw_next >= AF_TH);
      r_almost_empty <= (w_usedw_next < AE_TH);
    end
  end

`ifdef SCFIFO_S_OCC_ERR_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wrreq && r_full)  r_overflow  <= 1'b1;
      if (rdreq && r_empty) r_underflow <= 1'b1;
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign ram_wren     = w_wr_acc;
  assign ram_rden     = w_rd_acc;
  assign ram_wraddr   = w_wr_ptr;
  assign ram_rdaddr   = w_rd_ptr;
  assign usedw        = r_usedw;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;

endmodule
